// File: rtl/serial_parity_acc.sv
// serial_parity_acc: bit-serial parity accumulator built around a NAND-only
// two-input XOR stage. Each accepted bit is XORed with the running parity.
// After FRAME_LEN accepted bits, the frame result is presented on a
// valid/ready output port.
// Optional build macro: SERIAL_PARITY_ODD_EN.
// - Defined: the frame result is odd parity.
// - Undefined: the frame result is even parity.

// Two-input XOR made only from NAND gates.
// This is the same primitive used by the upstream XOR stage.
module NandXor (
  input  logic a_i,
  input  logic b_i,
  output logic y_o
);

  logic nandAb;
  logic nandA;
  logic nandB;

  assign nandAb = ~(a_i & b_i);
  assign nandA  = ~(a_i & nandAb);
  assign nandB  = ~(b_i & nandAb);
  assign y_o    = ~(nandA & nandB);

endmodule

module serial_parity_acc #(
  parameter int FRAME_LEN = 8,
  parameter int CNT_W     = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             in_valid,
  input  logic             in_bit,
  output logic             in_ready,
  output logic             out_valid,
  output logic             out_parity,
  input  logic             out_ready,
  output logic [CNT_W-1:0] bit_count
);

  typedef enum logic {
    ACCUM = 1'b0,
    HOLD  = 1'b1
  } state_e;

  // Index of the final bit of a frame.
  // When this bit is accepted, the frame result is produced.
  localparam logic [CNT_W-1:0] LastIdx = CNT_W'(FRAME_LEN - 1);

`ifdef SERIAL_PARITY_ODD_EN
  localparam logic ParityInvert = 1'b1;
`else
  localparam logic ParityInvert = 1'b0;
`endif

  state_e           state_q;
  state_e           state_d;
  logic             acc_q;
  logic             acc_d;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic             parity_q;
  logic             parity_d;
  logic             xorBit;
  logic             accept;

  NandXor u_xor (
    .a_i (acc_q),
    .b_i (in_bit),
    .y_o (xorBit)
  );

  assign in_ready   = (state_q == ACCUM) && !clear;
  assign accept     = in_valid && in_ready;
  assign out_valid  = (state_q == HOLD);
  assign out_parity = parity_q;
  assign bit_count  = cnt_q;

  // Next-state logic.
  // clear overrides accepting a bit and overrides handing off a result.
  // A result may leave only through an output transfer or a clear.
  always_comb begin
    state_d  = state_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    parity_d = parity_q;
    if (clear) begin
      state_d = ACCUM;
      acc_d   = 1'b0;
      cnt_d   = '0;
      if (state_q == HOLD) begin
        parity_d = 1'b0;
      end
    end else if (state_q == ACCUM) begin
      if (accept) begin
        if (cnt_q == LastIdx) begin
          parity_d = xorBit ^ ParityInvert;
          acc_d    = 1'b0;
          cnt_d    = '0;
          state_d  = HOLD;
        end else begin
          acc_d = xorBit;
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
    end else begin
      if (out_ready) begin
        state_d = ACCUM;
      end
    end
  end

  // State register.
  // Reset is asynchronous and drops any partial frame or pending result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ACCUM;
      acc_q    <= 1'b0;
      cnt_q    <= '0;
      parity_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      parity_q <= parity_d;
    end
  end

endmodule

// File: tb/tb_serial_parity_acc.sv
// Testbench for serial_parity_acc.
// Directed frames and random traffic are checked against a frame-level
// reference model. A scoreboard queue checks the results that leave
// through the output port.
module tb_serial_parity_acc;

  localparam int FRAME_LEN = 8;
  localparam int CNT_W     = 8;

`ifdef SERIAL_PARITY_ODD_EN
  localparam logic OddMode = 1'b1;
`else
  localparam logic OddMode = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             clear = 1'b0;
  logic             in_valid = 1'b0;
  logic             in_bit = 1'b0;
  logic             out_ready = 1'b0;
  logic             in_ready;
  logic             out_valid;
  logic             out_parity;
  logic [CNT_W-1:0] bit_count;

  int testsRun = 0;
  int testsFailed = 0;

  // Reference model state:
  // - bits accepted so far in the current frame
  // - whether a result is waiting for the consumer
  // - the value that out_parity should show
  logic expQ[$];
  logic mBits[$];
  logic mPending = 1'b0;
  logic mParity = 1'b0;

  serial_parity_acc #(
    .FRAME_LEN (FRAME_LEN),
    .CNT_W     (CNT_W)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .clear      (clear),
    .in_valid   (in_valid),
    .in_bit     (in_bit),
    .in_ready   (in_ready),
    .out_valid  (out_valid),
    .out_parity (out_parity),
    .out_ready  (out_ready),
    .bit_count  (bit_count)
  );

  always #5 clk = ~clk;

  task automatic check1(input string name, input logic [31:0] act, input logic [31:0] exp);
    testsRun++;
    if (act !== exp) begin
      testsFailed++;
      $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic refParity();
    logic p;
    p = OddMode;
    foreach (mBits[i]) p = p ^ mBits[i];
    return p;
  endfunction

  task automatic checkOutput();
    check1("in_ready", in_ready, !mPending && !clear);
    check1("bit_count", bit_count, mBits.size());
    check1("out_valid", out_valid, mPending);
    check1("out_parity", out_parity, mParity);
  endtask

  // Advance the reference model by one clock edge.
  // The model uses the inputs that were applied during that cycle.
  task automatic modelUpdate();
    if (clear) begin
      if (mPending) begin
        mPending = 1'b0;
        mParity  = 1'b0;
        if (expQ.size() > 0) void'(expQ.pop_back());
      end else begin
        mBits.delete();
      end
    end else if (mPending) begin
      if (out_ready) mPending = 1'b0;
    end else if (in_valid) begin
      mBits.push_back(in_bit);
      if (mBits.size() == FRAME_LEN) begin
        mParity = refParity();
        expQ.push_back(mParity);
        mBits.delete();
        mPending = 1'b1;
      end
    end
  endtask

  task automatic applyStimulus(input logic v, input logic b, input logic r, input logic c);
    in_valid  = v;
    in_bit    = b;
    out_ready = r;
    clear     = c;
    @(negedge clk);
    checkOutput();
    @(posedge clk);
    modelUpdate();
    #1;
  endtask

  // Hold rst_n low for n cycles while toggling in_bit.
  // Outputs must stay cleared for the whole time reset is held.
  task automatic holdReset(input int n);
    for (int i = 0; i < n; i++) begin
      in_valid = 1'b1;
      in_bit   = i[0];
      clear    = 1'b0;
      @(negedge clk);
      check1("rst_out_valid", out_valid, 1'b0);
      check1("rst_out_parity", out_parity, 1'b0);
      check1("rst_bit_count", bit_count, 0);
      @(posedge clk);
      #1;
    end
  endtask

  // Pulse rst_n low away from any clock edge.
  // The outputs must clear at once, without waiting for a clock.
  task automatic resetPulse();
    #2 rst_n = 1'b0;
    #1;
    check1("async_out_valid", out_valid, 1'b0);
    check1("async_out_parity", out_parity, 1'b0);
    check1("async_bit_count", bit_count, 0);
    mBits.delete();
    mPending = 1'b0;
    mParity  = 1'b0;
    expQ.delete();
    @(posedge clk);
    #1;
    holdReset(2);
    rst_n = 1'b1;
  endtask

  // Offer one bit and keep it on the input until the block takes it.
  // This mirrors an upstream stage that must hold its bit.
  task automatic sendBit(input logic b, input logic r);
    int guard;
    guard = 0;
    while (mPending && guard < 20) begin
      applyStimulus(1'b1, b, 1'b1, 1'b0);
      guard++;
    end
    applyStimulus(1'b1, b, r, 1'b0);
  endtask

  task automatic sendFrame(input logic [7:0] bits, input logic gap, input logic r);
    for (int i = 7; i >= 0; i--) begin
      if (gap) applyStimulus(1'b0, 1'b0, r, 1'b0);
      sendBit(bits[i], r);
    end
  endtask

  // Scoreboard monitor.
  // Whenever a result is handed to the consumer, compare it with the oldest
  // expected frame parity.
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready && !clear) begin
      testsRun++;
      if (expQ.size() == 0) begin
        testsFailed++;
        $display("[TB] FAIL scoreboard: out_valid=%0d with no expected result at %0t", out_valid, $time);
      end else begin
        logic exp;
        exp = expQ.pop_front();
        if (out_parity !== exp) begin
          testsFailed++;
          $display("[TB] FAIL scoreboard_parity: got %0d expected %0d at %0t", out_parity, exp, $time);
        end
      end
    end
  end

  initial begin
    rst_n = 1'b0;
    #1;
    holdReset(3);
    rst_n = 1'b1;
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);

    // Continuous frame with the consumer always ready.
    sendFrame(8'b10110010, 1'b0, 1'b1);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);

    // Back-pressured frame.
    // Offered bits must be ignored while the result is waiting.
    sendFrame(8'b11100000, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
    sendFrame(8'b10000000, 1'b0, 1'b1);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);

    // Gapped input stream.
    sendFrame(8'b00000001, 1'b1, 1'b1);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);

    // Clear a partial frame, then send a full frame.
    for (int i = 0; i < 4; i++) sendBit(1'b1, 1'b1);
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b1);
    sendFrame(8'b00000011, 1'b0, 1'b1);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);

    // Clear while a result is waiting.
    // The result must be dropped, not transferred.
    sendFrame(8'b10100100, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b1);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);

    // Asynchronous reset in the middle of a frame.
    for (int i = 0; i < 5; i++) sendBit(1'b1, 1'b1);
    resetPulse();
    sendFrame(8'b01000000, 1'b0, 1'b1);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);

    // Random traffic.
    for (int i = 0; i < 3000; i++) begin
      applyStimulus($urandom_range(0, 3) != 0, 1'($urandom % 2),
                    $urandom_range(0, 2) != 0, $urandom_range(0, 29) == 0);
    end

    // Drain any pending result, then require an empty scoreboard.
    for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
    check1("scoreboard_empty", expQ.size(), 0);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
